// File: rtl/pll_rst_lock_ctrl.sv
// PLL reset/lock sequencer: drives pll_rst, qualifies the asynchronous locked flag,
// holds the system in reset until lock is stable, retries failed locks and reports failure.
module pll_rst_lock_ctrl #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 256,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int MAX_RETRIES  = 3,
    parameter int CNT_W        = 17
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic       lock_lost,
    output logic [1:0] retry_cnt,
    output logic [7:0] lost_cnt
);

    typedef enum logic [2:0] {
        S_PRST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST   = CNT_W'(LOCK_STABLE - 1);
    localparam logic [1:0]       RETRY_LAST = 2'(MAX_RETRIES - 1);
    localparam logic [1:0]       RETRY_MAX  = 2'(MAX_RETRIES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    logic [7:0]       lost_q, lost_d;
    logic             sync1_q, sync1_d;
    logic             lkd_q, lkd_d;
    logic             lock_lost_q, lock_lost_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;
    logic             attempt_fail;

    always_comb begin
        sync1_d      = pll_locked;
        lkd_d        = sync1_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        retry_d      = retry_q;
        lost_d       = lost_q;
        lock_lost_d  = 1'b0;
        attempt_fail = 1'b0;

        if (relock_req) begin
            state_d = S_PRST;
            retry_d = '0;
        end else begin
            unique case (state_q)
                S_PRST: begin
                    if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
                S_WAIT_LOCK: begin
                    if (lkd_q)                  state_d      = S_STABLE;
                    else if (cnt_q == TMO_LAST) attempt_fail = 1'b1;
                    else                        cnt_d        = cnt_q + 1'b1;
                end
                S_STABLE: begin
                    if (!lkd_q) begin
                        attempt_fail = 1'b1;
                    end else if (cnt_q == STB_LAST) begin
                        state_d = S_RUN;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!lkd_q) begin
                        state_d     = S_PRST;
                        lock_lost_d = 1'b1;
                        if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
                    end
                end
                S_FAIL: ;
                default: state_d = S_PRST;
            endcase
        end

        if (attempt_fail) begin
            if (retry_q == RETRY_LAST) begin
                state_d = S_FAIL;
                retry_d = RETRY_MAX;
            end else begin
                state_d = S_PRST;
                retry_d = retry_q + 2'd1;
            end
        end

        // A relock request restarts the reset pulse even when already in PRST
        if (state_d != state_q || relock_req) cnt_d = '0;

        pll_rst_d = (state_d == S_PRST) || (state_d == S_FAIL);
        sys_rst_d = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
        fail_d    = (state_d == S_FAIL);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            lkd_q       <= 1'b0;
            state_q     <= S_PRST;
            cnt_q       <= '0;
            retry_q     <= '0;
            lost_q      <= '0;
            lock_lost_q <= 1'b0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            lkd_q       <= lkd_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            lost_q      <= lost_d;
            lock_lost_q <= lock_lost_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_q   <= sys_rst_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign lock_lost = lock_lost_q;
    assign retry_cnt = retry_q;
    assign lost_cnt  = lost_q;

endmodule

// File: tb/tb_pll_rst_lock_ctrl.sv
// Bench for pll_rst_lock_ctrl: directed scenarios plus random lock/relock/reset traffic,
// every cycle compared against a phase/timer reference model.
module tb_pll_rst_lock_ctrl;

    localparam int RC = 4;
    localparam int LS = 8;
    localparam int LT = 32;
    localparam int MR = 2;

    localparam int P_PRST = 0;
    localparam int P_WAIT = 1;
    localparam int P_STAB = 2;
    localparam int P_RUN  = 3;
    localparam int P_FAIL = 4;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic       lock_lost;
    logic [1:0] retry_cnt;
    logic [7:0] lost_cnt;

    int n_total;
    int n_bad;

    // reference model: current phase, time spent in it, bookkeeping counters
    int   m_phase;
    int   m_t;
    int   m_retry;
    int   m_lost;
    logic m_pulse;
    logic m_s1;
    logic m_s2;

    pll_rst_lock_ctrl #(
        .RST_CYCLES  (RC),
        .LOCK_STABLE (LS),
        .LOCK_TIMEOUT(LT),
        .MAX_RETRIES (MR),
        .CNT_W       (6)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .pll_locked(pll_locked),
        .relock_req(relock_req),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .fail      (fail),
        .lock_lost (lock_lost),
        .retry_cnt (retry_cnt),
        .lost_cnt  (lost_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_PRST;
        m_t     = 0;
        m_retry = 0;
        m_lost  = 0;
        m_pulse = 1'b0;
        m_s1    = 1'b0;
        m_s2    = 1'b0;
    endtask

    task automatic enter(input int ph);
        m_phase = ph;
        m_t     = 0;
    endtask

    task automatic attempt_failed();
        if (m_retry + 1 >= MR) begin
            enter(P_FAIL);
            m_retry = MR;
        end else begin
            enter(P_PRST);
            m_retry = m_retry + 1;
        end
    endtask

    task automatic model_step();
        logic lk;
        if (!rst_n) begin
            model_reset();
            return;
        end
        lk      = m_s2;
        m_s2    = m_s1;
        m_s1    = pll_locked;
        m_pulse = 1'b0;
        if (relock_req) begin
            enter(P_PRST);
            m_retry = 0;
        end else begin
            case (m_phase)
                P_PRST: if (m_t + 1 == RC) enter(P_WAIT); else m_t++;
                P_WAIT: if (lk) enter(P_STAB); else if (m_t + 1 == LT) attempt_failed(); else m_t++;
                P_STAB: begin
                    if (!lk) attempt_failed();
                    else if (m_t + 1 == LS) begin
                        enter(P_RUN);
                        m_retry = 0;
                    end else m_t++;
                end
                P_RUN: begin
                    if (!lk) begin
                        enter(P_PRST);
                        m_pulse = 1'b1;
                        if (m_lost < 255) m_lost++;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        chk("pll_rst",   int'(pll_rst),   int'(m_phase == P_PRST || m_phase == P_FAIL));
        chk("sys_rst",   int'(sys_rst),   int'(m_phase != P_RUN));
        chk("ready",     int'(ready),     int'(m_phase == P_RUN));
        chk("fail",      int'(fail),      int'(m_phase == P_FAIL));
        chk("lock_lost", int'(lock_lost), int'(m_pulse));
        chk("retry_cnt", int'(retry_cnt), m_retry);
        chk("lost_cnt",  int'(lost_cnt),  m_lost);
    endtask

    task automatic cyc();
        @(posedge refclk);
        model_step();
        @(negedge refclk);
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pll_rst"},   int'(pll_rst),   1);
        chk({tag, "_sys_rst"},   int'(sys_rst),   1);
        chk({tag, "_ready"},     int'(ready),     0);
        chk({tag, "_fail"},      int'(fail),      0);
        chk({tag, "_lock_lost"}, int'(lock_lost), 0);
        chk({tag, "_retry"},     int'(retry_cnt), 0);
        chk({tag, "_lost"},      int'(lost_cnt),  0);
    endtask

    task automatic do_async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values(tag);
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (ready) break;
            cyc();
        end
        chk(tag, int'(ready), 1);
    endtask

    task automatic wait_stab(input string tag, input int t);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (m_phase == P_STAB && m_t == t) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        chk(tag, int'(found), 1);
    endtask

    int cnt_a;
    int cnt_b;
    int saved_lost;
    int len;

    initial begin
        n_total    = 0;
        n_bad      = 0;
        rst_n      = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        check_reset_values("por");
        cyc();
        cyc();
        rst_n = 1'b1;

        // clean bring-up: pll_rst width and lock-to-ready latency
        cnt_a = int'(pll_rst);
        for (int i = 0; i < 10; i++) begin
            cyc();
            cnt_a += int'(pll_rst);
        end
        chk("t1_prst_width", cnt_a, RC);
        pll_locked = 1'b1;
        cnt_b = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            cnt_b++;
            if (ready) break;
        end
        chk("t1_ready_edges", cnt_b, LS + 3);
        chk("t1_retry", int'(retry_cnt), 0);

        // lock lost in RUN for 5 cycles
        pll_locked = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 25; i++) begin
            if (i == 5) pll_locked = 1'b1;
            cyc();
            cnt_a += int'(lock_lost);
            cnt_b += int'(pll_rst);
        end
        chk("t3_pulses", cnt_a, 1);
        chk("t3_lost", int'(lost_cnt), 1);
        chk("t3_prst_width", cnt_b, RC);
        chk("t3_ready", int'(ready), 1);

        // sub-period glitch between edges is never sampled
        #1 pll_locked = 1'b0;
        #2 pll_locked = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        chk("glitch_ready", int'(ready), 1);
        chk("glitch_lost", int'(lost_cnt), 1);

        // relock in the same cycle the lock drop reaches the FSM
        saved_lost = int'(lost_cnt);
        pll_locked = 1'b0;
        cyc();
        cyc();
        relock_req = 1'b1;
        cyc();
        relock_req = 1'b0;
        chk("rl_no_pulse", int'(lock_lost), 0);
        chk("rl_lost_kept", int'(lost_cnt), saved_lost);
        chk("rl_prst", int'(pll_rst), 1);
        pll_locked = 1'b1;
        wait_ready("rl_ready");

        // captured glitch at STABLE cnt=5
        relock_req = 1'b1;
        cyc();
        relock_req = 1'b0;
        wait_stab("t4_reach_stab", 3);
        pll_locked = 1'b0;
        cyc();
        pll_locked = 1'b1;
        cyc();
        cyc();
        chk("t4_retry", int'(retry_cnt), 1);
        chk("t4_prst", int'(pll_rst), 1);
        wait_ready("t4_ready");
        chk("t4_retry_clr", int'(retry_cnt), 0);

        // no lock at all: two timeouts then FAIL
        pll_locked = 1'b0;
        do_async_reset("t2_rst");
        for (int i = 0; i < 90; i++) cyc();
        chk("t2_fail", int'(fail), 1);
        chk("t2_retry", int'(retry_cnt), MR);
        chk("t2_pll_rst", int'(pll_rst), 1);
        chk("t2_sys_rst", int'(sys_rst), 1);

        // relock out of FAIL
        relock_req = 1'b1;
        cyc();
        relock_req = 1'b0;
        chk("t5_fail", int'(fail), 0);
        chk("t5_pll_rst", int'(pll_rst), 1);
        chk("t5_retry", int'(retry_cnt), 0);
        pll_locked = 1'b1;
        wait_ready("t5_ready");

        // async reset mid-STABLE and mid-RUN
        relock_req = 1'b1;
        cyc();
        relock_req = 1'b0;
        wait_stab("t6_reach_stab", 4);
        do_async_reset("t6_stab_rst");
        wait_ready("t6_ready");
        cyc();
        cyc();
        do_async_reset("t6_run_rst");

        // 256 losses saturate lost_cnt
        for (int k = 0; k < 256; k++) begin
            wait_ready("sat_ready");
            pll_locked = 1'b0;
            cyc();
            cyc();
            cyc();
            pll_locked = 1'b1;
        end
        wait_ready("sat_final_ready");
        chk("t6_lost_sat", int'(lost_cnt), 255);

        // random traffic
        for (int i = 0; i < 150; i++) begin
            len        = $urandom_range(1, 30);
            pll_locked = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < len; j++) begin
                relock_req = ($urandom_range(0, 63) == 0);
                cyc();
            end
            relock_req = 1'b0;
            if ($urandom_range(0, 19) == 0) do_async_reset("rnd_rst");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
